sigma_bus_arb2: RTL
===================

Name: sigma_bus_arb2

Overview:
- Two-master to one-slave arbiter for the sigma SoC memory-mapped bus (req/ack/resp protocol).
- Shares the SoC bus between the CPU data port (m0) and the UART debug master (m1), so a host can load and inspect memory over the UART while the core runs.
- Adds round-robin fairness, holds the grant across a read's response phase, and adds a watchdog that completes a stalled transaction.

Parameters:
- FIXED_PRIO, 0, 1 = m0 always wins a tie; 0 = round-robin.
- TIMEOUT, 1023, cycles in REQ or RESP before forced completion; 0 disables the watchdog.
- ERR_RDATA, 32'hDEADBEEF, rdata returned on a timed-out read.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- mN_req_i  in  1  master N request (N = 0, 1; every mN_* port exists for both masters)
- mN_we_i  in  1  master N write enable
- mN_addr_i  in  32  master N address
- mN_be_i  in  4  master N byte enables
- mN_wdata_i  in  32  master N write data
- mN_ack_o  out  1  master N request accepted
- mN_resp_o  out  1  master N read data valid
- mN_rdata_o  out  32  master N read data
- s_req_o  out  1  slave request
- s_we_o  out  1  slave write enable
- s_addr_o  out  32  slave address
- s_be_o  out  4  slave byte enables
- s_wdata_o  out  32  slave write data
- s_ack_i  in  1  slave accepted
- s_resp_i  in  1  slave read data valid
- s_rdata_i  in  32  slave read data
- timeout_o  out  1  one-cycle pulse on forced completion
- busy_o  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk_i, rst_i). On reset:
  - state = IDLE, grant = m0, last = m1 (m0 wins the first tie), timer = 0.
  - All outputs 0.
- Master protocol: a master holds req, we, addr, be and wdata stable from assertion until its ack.
- IDLE:
  - No req: stay in IDLE.
  - Otherwise select a winner. With one requester, it wins. With both, FIXED_PRIO=1 picks m0; FIXED_PRIO=0 picks the master other than last.
  - Register grant, go to REQ. Arbitration latency is 1 cycle; s_req_o is never asserted from IDLE.
- REQ:
  - s_* outputs mirror the granted master's inputs (combinational mux on the registered grant).
  - s_req_o = granted master's req.
  - On s_ack_i: mN_ack_o=1 to the granted master in the same cycle; last = grant.
  - After the ack, a write returns to IDLE and a read goes to RESP.
  - Granted master drops req before ack (abort): return to IDLE next cycle, no ack issued.
- RESP:
  - s_req_o = 0 and the grant is held; the other master waits.
  - On s_resp_i: mN_resp_o=1 and mN_rdata_o=s_rdata_i to the granted master in the same cycle, then IDLE.
  - s_resp_i in the same cycle as s_ack_i is not allowed; the slave responds no earlier than 1 cycle after ack.
- Non-granted outputs: ack, resp and rdata of the non-granted master are 0 at all times.
- Throughput: back-to-back, the same master can be re-granted from IDLE 1 cycle after completion. Minimum write = 2 cycles (IDLE, REQ with ack); minimum read = 3 cycles.
- Watchdog (TIMEOUT != 0):
  - timer clears on entry to REQ or RESP and increments each cycle there; it saturates and never wraps.
  - timer == TIMEOUT in REQ: ack the master, drop s_req_o. A write goes to IDLE; a read goes to RESP with a forced response next cycle.
  - timer == TIMEOUT in RESP: resp=1, rdata=ERR_RDATA, then IDLE.
  - timeout_o pulses 1 cycle for each forced ack and each forced resp.
  - A real ack/resp in the same cycle as expiry wins: the slave data is used and there is no timeout_o pulse.
  - A late s_resp_i arriving in IDLE after a forced completion is ignored.
- Reset mid-transaction: immediate return to IDLE, s_req_o=0 in the next cycle, no ack/resp generated.

Decomposition:
- Package sigma_bus_arb_pkg:
  - state enum {IDLE, REQ, RESP}
  - MASTERS=2 and master index typedef
  - bus request struct (we, addr, be, wdata)
  - ERR_RDATA default
- Sub-module sigma_rr_sel: combinational 2-way round-robin/fixed-priority selector (inputs: req vector, last, fixed flag; output: winner index). It is reused by later N-master versions.

Test Plan:
- Single m0 write, addr=32'h0000_1000, wdata=32'h1234_5678, be=4'hF, slave acks in cycle 1 of REQ -> s_req_o high exactly 1 cycle, m0_ack_o pulses once, busy_o drops the next cycle, m1 outputs all 0.
- Both masters assert reads in the same cycle from reset, FIXED_PRIO=0, slave resp 2 cycles after ack with rdata=32'hA5A5_0001 / 32'hA5A5_0002 -> m0 served first and receives ...0001, m1 serves next and receives ...0002, never interleaved.
- Both masters continuously request, 8 transactions -> grants alternate m0,m1,m0,...; with FIXED_PRIO=1, all 8 go to m0.
- m1 read, slave never responds, TIMEOUT=15 -> m1_resp_o asserted with rdata=32'hDEADBEEF and timeout_o pulse; a subsequent m0 write completes normally.
- s_ack_i coincides with watchdog expiry -> normal ack, timeout_o stays 0.
- rst_i asserted during RESP -> next cycle s_req_o=0, busy_o=0, no resp to either master; a following m1 write completes in 2 cycles.

Source files
------------

// File: rtl/sigma_bus_arb2_pkg.sv
// Shared types for the sigma bus arbiters: FSM states, master index, request bundle.
package sigma_bus_arb_pkg;

  localparam int unsigned MASTERS = 2;
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

  typedef logic [$clog2(MASTERS)-1:0] midx_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/sigma_bus_arb2_rr_sel.sv
// Two-way winner selection: single requester wins; on a tie either m0 (fixed)
// or the master that was not served last (round-robin).
module sigma_rr_sel
  import sigma_bus_arb_pkg::*;
(
  input  logic [MASTERS-1:0] req,
  input  midx_t              last,
  input  logic               fixed,
  output midx_t              winner
);

  always_comb begin
    winner = '0;
    if (req[1] && !req[0]) begin
      winner = midx_t'(1);
    end else if (req[1] && req[0]) begin
      winner = fixed ? midx_t'(0) : ~last;
    end
  end

endmodule

// File: rtl/sigma_bus_arb2.sv
// Two-master to one-slave arbiter for the sigma req/ack/resp bus, with grant held
// through the read response phase and a watchdog that completes stalled transfers.
module sigma_bus_arb2
  import sigma_bus_arb_pkg::*;
#(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned TIMEOUT    = 1023,
  parameter logic [31:0] ERR_RDATA  = ERR_RDATA_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_ack_o,
  output logic        m0_resp_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_ack_o,
  output logic        m1_resp_o,
  output logic [31:0] m1_rdata_o,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_ack_i,
  input  logic        s_resp_i,
  input  logic [31:0] s_rdata_i,
  output logic        timeout_o,
  output logic        busy_o
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT);

  state_t             state, state_next;
  midx_t              grant, grant_next;
  midx_t              last, last_next;
  midx_t              winner;
  logic               force_resp, force_resp_next;
  logic [TW-1:0]      timer;
  logic [MASTERS-1:0] m_req;
  bus_req_t           m0_bus, m1_bus, g_bus, s_bus;
  logic               g_req, expired;
  logic               ack_g, resp_g, tmo, s_req;
  logic [31:0]        rdata;

  assign m_req   = {m1_req_i, m0_req_i};
  assign m0_bus  = '{we: m0_we_i, addr: m0_addr_i, be: m0_be_i, wdata: m0_wdata_i};
  assign m1_bus  = '{we: m1_we_i, addr: m1_addr_i, be: m1_be_i, wdata: m1_wdata_i};
  assign g_bus   = (grant == midx_t'(1)) ? m1_bus : m0_bus;
  assign g_req   = m_req[grant];
  assign expired = (TIMEOUT != 0) && (timer == T_LIMIT);

  sigma_rr_sel u_sel (
    .req    (m_req),
    .last   (last),
    .fixed  (FIXED_PRIO),
    .winner (winner)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      grant      <= midx_t'(0);
      last       <= midx_t'(MASTERS - 1);
      force_resp <= 1'b0;
      timer      <= '0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last       <= last_next;
      force_resp <= force_resp_next;
      if (state == IDLE || state_next != state) begin
        timer <= '0;
      end else if (timer != '1) begin
        timer <= timer + 1'b1;
      end
    end
  end

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_next       = last;
    force_resp_next = force_resp;
    ack_g           = 1'b0;
    resp_g          = 1'b0;
    tmo             = 1'b0;
    s_req           = 1'b0;
    s_bus           = '0;
    rdata           = '0;
    unique case (state)
      IDLE: begin
        if (|m_req) begin
          grant_next = winner;
          state_next = REQ;
        end
      end
      REQ: begin
        s_bus = g_bus;
        if (!g_req) begin
          state_next = IDLE;
        end else begin
          s_req = 1'b1;
          // A real slave ack in the expiry cycle takes precedence over the watchdog.
          if (s_ack_i || expired) begin
            ack_g           = 1'b1;
            last_next       = grant;
            state_next      = g_bus.we ? IDLE : RESP;
            force_resp_next = !s_ack_i && !g_bus.we;
            if (!s_ack_i) begin
              s_req = 1'b0;
              tmo   = 1'b1;
            end
          end
        end
      end
      RESP: begin
        if (s_resp_i) begin
          resp_g          = 1'b1;
          rdata           = s_rdata_i;
          state_next      = IDLE;
          force_resp_next = 1'b0;
        end else if (force_resp || expired) begin
          resp_g          = 1'b1;
          rdata           = ERR_RDATA;
          tmo             = 1'b1;
          state_next      = IDLE;
          force_resp_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
    // Completions are suppressed in a reset cycle so an interrupted transfer never finishes.
    if (rst_i) begin
      ack_g  = 1'b0;
      resp_g = 1'b0;
      tmo    = 1'b0;
      rdata  = '0;
    end
  end

  assign m0_ack_o   = ack_g  && (grant == midx_t'(0));
  assign m1_ack_o   = ack_g  && (grant == midx_t'(1));
  assign m0_resp_o  = resp_g && (grant == midx_t'(0));
  assign m1_resp_o  = resp_g && (grant == midx_t'(1));
  assign m0_rdata_o = (grant == midx_t'(0)) ? rdata : '0;
  assign m1_rdata_o = (grant == midx_t'(1)) ? rdata : '0;

  assign s_req_o   = s_req;
  assign s_we_o    = s_bus.we;
  assign s_addr_o  = s_bus.addr;
  assign s_be_o    = s_bus.be;
  assign s_wdata_o = s_bus.wdata;
  assign timeout_o = tmo;
  assign busy_o    = (state != IDLE);

endmodule
